// File: rtl/pyr_dense_optical_flow_accel_mul_arb.sv
// Round-robin arbiter sharing one pipelined signed multiplier, with flush.
// Define MUL_ARB_STATS_EN to add issue/stall statistics counters.
module pyr_dense_optical_flow_accel_mul_arb #(
  parameter int NUM_REQ = 4,
  parameter int A_W     = 9,
  parameter int B_W     = 17,
  parameter int P_W     = 26,
  parameter int MUL_LAT = 3,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [P_W-1:0]         rsp_p,
  output logic                   mul_ce,
  output logic [A_W-1:0]         mul_a,
  output logic [B_W-1:0]         mul_b,
  input  logic [P_W-1:0]         mul_p,
  input  logic                   flush_req,
  output logic                   flush_done,
  output logic                   busy
`ifdef MUL_ARB_STATS_EN
  ,
  output logic [31:0]            stat_issue_cnt,
  output logic [31:0]            stat_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t            state_q;
  logic              flush_done_q;
  logic [ID_W-1:0]   ptr_q;
  logic [MUL_LAT-1:0] vld_q;
  logic [ID_W-1:0]   id_q [MUL_LAT];
  logic [A_W-1:0]    mul_a_q;
  logic [B_W-1:0]    mul_b_q;

  logic [A_W-1:0]    a_arr [NUM_REQ];
  logic [B_W-1:0]    b_arr [NUM_REQ];
  logic [NUM_REQ-1:0] gnt_oh;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W-1:0]   idx_id;
  logic              found;
  int                idx;
  logic              grant_en;
  logic              issue;
  logic [A_W-1:0]    a_d;
  logic [B_W-1:0]    b_d;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*A_W +: A_W];
    assign b_arr[g] = req_b[g*B_W +: B_W];
  end

  assign rsp_valid  = vld_q[MUL_LAT-1];
  assign rsp_id     = id_q[MUL_LAT-1];
  assign rsp_p      = mul_p;
  assign mul_ce     = !(rsp_valid && !rsp_ready);
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign flush_done = flush_done_q;
  assign busy       = |vld_q;

  // Flush has priority over any request seen in the same cycle.
  assign grant_en = reset_n && (state_q == RUN) && !flush_req && mul_ce;

  always_comb begin
    gnt_oh = '0;
    gnt_id = '0;
    idx_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_id = ID_W'(idx);
      if (!found && req_valid[idx_id]) begin
        found          = 1'b1;
        gnt_id         = idx_id;
        gnt_oh[idx_id] = 1'b1;
      end
    end
  end

  assign req_ready = grant_en ? gnt_oh : '0;
  assign issue     = |(req_valid & req_ready);
  assign a_d       = issue ? a_arr[gnt_id] : '0;
  assign b_d       = issue ? b_arr[gnt_id] : '0;

  // Operand register acts as the first multiplier stage, so it stalls too.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q   <= '0;
      ptr_q   <= ID_W'(NUM_REQ-1);
      mul_a_q <= '0;
      mul_b_q <= '0;
      for (int i = 0; i < MUL_LAT; i++) id_q[i] <= '0;
    end else if (mul_ce) begin
      mul_a_q  <= a_d;
      mul_b_q  <= b_d;
      vld_q[0] <= issue;
      id_q[0]  <= issue ? gnt_id : '0;
      for (int i = 1; i < MUL_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
      if (issue) ptr_q <= gnt_id;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RUN;
      flush_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (flush_req) state_q <= DRAIN;
        end
        DRAIN: begin
          if (!flush_req) begin
            state_q <= RUN;
          end else if (!busy) begin
            state_q      <= HALT;
            flush_done_q <= 1'b1;
          end
        end
        HALT: begin
          if (!flush_req) begin
            state_q      <= RUN;
            flush_done_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= RUN;
          flush_done_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef MUL_ARB_STATS_EN
  logic [31:0] issue_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (issue)   issue_cnt_q <= issue_cnt_q + 32'd1;
      if (!mul_ce) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stat_issue_cnt = issue_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule
